// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one command per start, one bit step per clock,
// with start/busy/done handshake and live serial fill from L/R.
//
// state   | meaning
// S_IDLE  | waiting for start; accepts and latches a command
// S_SHIFT | one shift/rotate step per edge until cnt reaches 1
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module seq_shifter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [CW-1:0] amt,
  input  logic [W-1:0]  DATA,
  input  logic          L,
  input  logic          R,
  output logic [W-1:0]  A,
  output logic          cout,
  output logic          busy,
  output logic          done,
  output logic          zero
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SAR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [CW-1:0] W_CNT = CW'(W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] n_amt;

  // Amounts beyond the register width behave exactly like a full-width shift.
  assign n_amt = (amt > W_CNT) ? W_CNT : amt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      a_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = n_amt;
          cout_d = 1'b0;
          case (op)
            OP_LOAD: begin a_d = DATA; state_d = S_DONE; end
            OP_CLR:  begin a_d = '0;   state_d = S_DONE; end
            OP_NOP:  state_d = S_DONE;
            default: state_d = (n_amt == '0) ? S_DONE : S_SHIFT;
          endcase
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_SHL: begin a_d = {a_q[W-2:0], R};        cout_d = a_q[W-1]; end
          OP_SHR: begin a_d = {L, a_q[W-1:1]};        cout_d = a_q[0];   end
          OP_SAR: begin a_d = {a_q[W-1], a_q[W-1:1]}; cout_d = a_q[0];   end
          OP_ROL: begin a_d = {a_q[W-2:0], a_q[W-1]}; cout_d = a_q[W-1]; end
          OP_ROR: begin a_d = {a_q[0], a_q[W-1:1]};   cout_d = a_q[0];   end
          default: ;
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign A    = a_q;
  assign cout = cout_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign zero = (a_q == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter at W = 8, 16 and 2 with hand-computed results.
module tb_seq_shifter;

  localparam logic [2:0] LD = 3'b000, SHL = 3'b001, SHR = 3'b010, SAR = 3'b011;
  localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, CLR = 3'b110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 0, l8 = 0, r8 = 0, c8, b8, dn8, z8;
  logic [2:0]  o8 = 0;
  logic [3:0]  a8 = 0;
  logic [7:0]  d8 = 0, q8;
  logic        s16 = 0, l16 = 0, r16 = 0, c16, b16, dn16, z16;
  logic [2:0]  o16 = 0;
  logic [4:0]  a16 = 0;
  logic [15:0] d16 = 0, q16;
  logic        s2 = 0, l2 = 0, r2 = 0, c2, b2, dn2, z2;
  logic [2:0]  o2 = 0;
  logic [1:0]  a2 = 0, d2 = 0, q2;

  seq_shifter #(.W(8)) u8 (.clk(clk), .reset(reset), .start(s8), .op(o8), .amt(a8),
    .DATA(d8), .L(l8), .R(r8), .A(q8), .cout(c8), .busy(b8), .done(dn8), .zero(z8));
  seq_shifter #(.W(16)) u16 (.clk(clk), .reset(reset), .start(s16), .op(o16), .amt(a16),
    .DATA(d16), .L(l16), .R(r16), .A(q16), .cout(c16), .busy(b16), .done(dn16), .zero(z16));
  seq_shifter #(.W(2)) u2 (.clk(clk), .reset(reset), .start(s2), .op(o2), .amt(a2),
    .DATA(d2), .L(l2), .R(r2), .A(q2), .cout(c2), .busy(b2), .done(dn2), .zero(z2));

  int vectors = 0;
  int miscompares = 0;
  int bc, dc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bz(input int w);
    return (w == 8) ? b8 : (w == 16) ? b16 : b2;
  endfunction

  function automatic logic dz(input int w);
    return (w == 8) ? dn8 : (w == 16) ? dn16 : dn2;
  endfunction

  // Issues one command and counts busy/done cycles (sampled on falling edges).
  // inj pulses a CLR start on the W=8 unit during its first busy cycle.
  task automatic cmd(input int w, input logic [2:0] o, input logic [4:0] a,
                     input logic [15:0] d, input logic l, input logic r, input bit inj,
                     output int nb, output int nd);
    @(negedge clk);
    case (w)
      8:  begin s8 = 1;  o8 = o;  a8 = a[3:0]; d8 = d[7:0];  l8 = l;  r8 = r;  end
      16: begin s16 = 1; o16 = o; a16 = a;     d16 = d;      l16 = l; r16 = r; end
      default: begin s2 = 1; o2 = o; a2 = a[1:0]; d2 = d[1:0]; l2 = l; r2 = r; end
    endcase
    @(posedge clk);
    @(negedge clk);
    s8 = 0; s16 = 0; s2 = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bz(w)) break;
      nb++;
      if (dz(w)) nd++;
      if (inj && nb == 1) begin s8 = 1; o8 = CLR; end
      else s8 = 0;
      @(negedge clk);
    end
    s8 = 0;
  endtask

  initial begin
    #12;
    chk("rst_A", 16'(q8), 16'h0);
    chk("rst_cout", 16'(c8), 16'h0);
    chk("rst_busy", 16'(b8), 16'h0);
    chk("rst_done", 16'(dn8), 16'h0);
    chk("rst_zero", 16'(z8), 16'h1);
    @(negedge clk);
    reset = 0;

    cmd(8, LD, 5'd0, 16'h0096, 0, 0, 0, bc, dc);
    chk("load_A", 16'(q8), 16'h0096);
    chk("load_busy", 16'(bc), 16'd1);
    chk("load_done", 16'(dc), 16'd1);

    cmd(8, SHL, 5'd3, 16'h0, 0, 1, 0, bc, dc);
    chk("shl3_A", 16'(q8), 16'h00B7);
    chk("shl3_cout", 16'(c8), 16'h0);
    chk("shl3_busy", 16'(bc), 16'd4);
    chk("shl3_done", 16'(dc), 16'd1);

    cmd(8, LD, 5'd0, 16'h0080, 0, 0, 0, bc, dc);
    cmd(8, SAR, 5'd2, 16'h0, 0, 0, 0, bc, dc);
    chk("sar2_A", 16'(q8), 16'h00E0);
    chk("sar2_cout", 16'(c8), 16'h0);

    cmd(8, LD, 5'd0, 16'h0081, 0, 0, 0, bc, dc);
    cmd(8, ROR, 5'd1, 16'h0, 0, 0, 0, bc, dc);
    chk("ror1_A", 16'(q8), 16'h00C0);
    chk("ror1_cout", 16'(c8), 16'h1);

    cmd(8, LD, 5'd0, 16'h00A5, 0, 0, 0, bc, dc);
    cmd(8, ROL, 5'd8, 16'h0, 0, 0, 0, bc, dc);
    chk("rol8_A", 16'(q8), 16'h00A5);
    chk("rol8_cout", 16'(c8), 16'h1);
    chk("rol8_busy", 16'(bc), 16'd9);

    cmd(8, LD, 5'd0, 16'h00FF, 0, 0, 0, bc, dc);
    cmd(8, SHR, 5'd15, 16'h0, 0, 0, 0, bc, dc);
    chk("clamp_A", 16'(q8), 16'h0);
    chk("clamp_zero", 16'(z8), 16'h1);
    chk("clamp_cout", 16'(c8), 16'h1);
    chk("clamp_busy", 16'(bc), 16'd9);

    cmd(8, LD, 5'd0, 16'h005A, 0, 0, 0, bc, dc);
    cmd(8, SHL, 5'd0, 16'h0, 0, 1, 0, bc, dc);
    chk("amt0_A", 16'(q8), 16'h005A);
    chk("amt0_busy", 16'(bc), 16'd1);
    chk("amt0_done", 16'(dc), 16'd1);

    cmd(8, SHL, 5'd4, 16'h0, 0, 0, 1, bc, dc);
    chk("ign_A", 16'(q8), 16'h00A0);
    chk("ign_cout", 16'(c8), 16'h1);
    chk("ign_busy", 16'(bc), 16'd5);

    cmd(8, CLR, 5'd0, 16'h0, 0, 0, 0, bc, dc);
    chk("clr_A", 16'(q8), 16'h0);
    chk("clr_zero", 16'(z8), 16'h1);

    cmd(8, LD, 5'd0, 16'h00FF, 0, 0, 0, bc, dc);
    @(negedge clk);
    s8 = 1; o8 = SHR; a8 = 4'd5; l8 = 0;
    @(posedge clk);
    @(negedge clk);
    s8 = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("abort_A", 16'(q8), 16'h0);
    chk("abort_busy", 16'(b8), 16'h0);
    chk("abort_done", 16'(dn8), 16'h0);
    chk("abort_cout", 16'(c8), 16'h0);
    @(negedge clk);
    reset = 0;
    cmd(8, LD, 5'd0, 16'h003C, 0, 0, 0, bc, dc);
    chk("reload_A", 16'(q8), 16'h003C);
    chk("reload_done", 16'(dc), 16'd1);

    cmd(16, LD, 5'd0, 16'h8001, 0, 0, 0, bc, dc);
    cmd(16, SAR, 5'd4, 16'h0, 0, 0, 0, bc, dc);
    chk("w16_sar_A", q16, 16'hF800);
    chk("w16_sar_cout", 16'(c16), 16'h0);
    chk("w16_sar_busy", 16'(bc), 16'd5);
    cmd(16, LD, 5'd0, 16'h0096, 0, 0, 0, bc, dc);
    cmd(16, SHL, 5'd3, 16'h0, 0, 1, 0, bc, dc);
    chk("w16_shl_A", q16, 16'h04B7);
    chk("w16_shl_cout", 16'(c16), 16'h0);
    chk("w16_shl_busy", 16'(bc), 16'd4);

    cmd(2, LD, 5'd0, 16'h0002, 0, 0, 0, bc, dc);
    cmd(2, SHL, 5'd3, 16'h0, 0, 1, 0, bc, dc);
    chk("w2_shl_A", 16'(q2), 16'h3);
    chk("w2_shl_cout", 16'(c2), 16'h0);
    chk("w2_shl_busy", 16'(bc), 16'd3);
    cmd(2, LD, 5'd0, 16'h0002, 0, 0, 0, bc, dc);
    cmd(2, SAR, 5'd2, 16'h0, 0, 0, 0, bc, dc);
    chk("w2_sar_A", 16'(q2), 16'h3);
    chk("w2_sar_cout", 16'(c2), 16'h1);
    chk("w2_sar_done", 16'(dc), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shift unit for the arithmetic-logic processor datapath. It replaces the single-step shift register with one that performs a whole operation per command. Supported operations are parallel load, clear, logical and arithmetic shifts, and rotates. Shifts run one bit per clock for a programmable amount and use a start/busy/done handshake. Serial fill bits are taken live from L/R on every shift step, so the block can also stream bits in.

## Interface
Parameters:
- W, 8, data width; legal values are W >= 2.
- CW, $clog2(W+1), width of the shift-amount input.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  operation code: 000 LOAD, 001 SHL, 010 SHR, 011 SAR, 100 ROL, 101 ROR, 110 CLR, 111 NOP.
- amt  in  CW  shift amount; sampled with start.
- DATA  in  W  parallel load value; sampled with start.
- L  in  1  fill bit entering A[W-1] on SHR.
- R  in  1  fill bit entering A[0] on SHL.
- A  out  W  register contents.
- cout  out  1  last bit shifted or rotated out.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle completion pulse.
- zero  out  1  combinational flag, (A == 0).

## Operation
- FSM states:
  - IDLE: waits for start.
  - SHIFT: performs one bit step per edge.
  - DONE: one cycle, then returns to IDLE.
- Accept edge (IDLE and start=1):
  - Latch op.
  - n = min(amt, W); cnt <= n.
  - cout <= 0.
- Action at the accept edge, by op:
  - LOAD: A <= DATA; go to DONE.
  - CLR: A <= 0; go to DONE.
  - NOP: A unchanged; go to DONE.
  - Shift or rotate with n = 0: A unchanged; go to DONE.
  - Shift or rotate with n > 0: go to SHIFT.
- One step per edge in SHIFT, with cout <= the bit leaving A:
  - SHL: A <= {A[W-2:0], R}; cout <= A[W-1].
  - SHR: A <= {L, A[W-1:1]}; cout <= A[0].
  - SAR: A <= {A[W-1], A[W-1:1]}; cout <= A[0].
  - ROL: A <= {A[W-2:0], A[W-1]}; cout <= A[W-1].
  - ROR: A <= {A[0], A[W-1:1]}; cout <= A[0].
- Counter: cnt decrements once per step. The edge with cnt == 1 performs the final step and moves to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. A and cout hold until the next accepted command.
- start while busy (SHIFT or DONE) is ignored. It is neither queued nor able to alter op, amt or DATA in flight.
- L and R are sampled at every shift edge, not latched at start.
- amt > W is clamped to W. After W steps, SHL/SHR leave the register filled entirely with R/L respectively, and ROL/ROR return the original value.

## Timing
- Reset (async assert, any state): A = 0, cout = 0, busy = 0, done = 0, state = IDLE, cnt = 0. zero = 1 while A = 0. Reset may abort an operation in progress.
- Reset release: the first accepting edge is the first rising clk edge after reset deasserts.
- Shift/rotate with n > 0: start sampled at edge E0. busy is high from E0 to E0+n+1, i.e. n+1 cycles. The final A is visible after edge E0+n. done is high during the cycle after E0+n.
- LOAD, CLR, NOP, or n = 0: A is updated at E0. busy and done are both high for the single cycle after E0.
- Back-to-back: start held high continuously gives one accept per IDLE cycle. Throughput is one command every n+2 cycles.
- done and busy are registered outputs; zero is combinational from A.

## Test plan
- Reset mid-shift:
  - Stimulus: SHR by 5 on 8'hFF; assert reset asynchronously after 2 steps.
  - Required: A = 0, busy = 0, done = 0 and cout = 0 immediately, without waiting for a clock edge. After release, LOAD 8'h3C gives A = 8'h3C one edge later and a single done pulse.
- SHL streaming, W = 8:
  - Stimulus: LOAD 8'b1001_0110, then SHL amt = 3 with R = 1.
  - Required: A = 8'b1011_0111, cout = 0, busy high for exactly 4 cycles, done for 1 cycle.
- Arithmetic shift and rotate:
  - Stimulus 1: SAR amt = 2 on 8'h80. Required: A = 8'hE0, cout = 0.
  - Stimulus 2: ROR amt = 1 on 8'h81. Required: A = 8'hC0, cout = 1.
  - Stimulus 3: ROL amt = 8 on 8'hA5. Required: A = 8'hA5.
- Clamp and zero flag:
  - Stimulus: LOAD 8'hFF, then SHR amt = 15 with L = 0.
  - Required: exactly 8 steps, busy for 9 cycles, A = 0, zero = 1, cout = 1.
- Degenerate and ignored commands:
  - amt = 0 SHL: A unchanged; busy and done high for 1 cycle.
  - start pulsed with op = CLR during SHIFT of a 4-step SHL: ignored; the SHL result is correct.
  - CLR issued after done: A = 0.
- Parametrisation:
  - Repeat the SHL and SAR scenarios at W = 2 and W = 16.
  - W = 16, SAR amt = 4 on 16'h8001: A = 16'hF800, cout = 0.
